// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked two's-complement ALU with single-cycle ops and a shift-add multiplier
// Results and flags are registered on entry to DONE and held until the sink takes them.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_NOT = 3'd2;
  localparam logic [2:0] F_AND = 3'd3;
  localparam logic [2:0] F_OR  = 3'd4;
  localparam logic [2:0] F_XOR = 3'd5;
  localparam logic [2:0] F_SLT = 3'd6;
  localparam logic [2:0] F_MUL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_overflow;
  logic               r_zero;

  logic               w_hs;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [2*WIDTH-1:0] w_acc_next;

  assign in_ready  = !rst && (r_state == S_IDLE || (r_state == S_DONE && out_ready));
  assign w_hs      = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (func)
      F_ADD: begin
        w_sum = {1'b0, a} + {1'b0, b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] == b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      F_SUB: begin
        // carry out of a + ~b + 1 is the no-borrow indication
        w_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (a[MSB] != b[MSB]) && (w_res[MSB] != a[MSB]);
      end
      F_NOT:   w_res = ~a;
      F_AND:   w_res = a & b;
      F_OR:    w_res = a | b;
      F_XOR:   w_res = a ^ b;
      F_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_res = '0;
    endcase
  end

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else if (w_hs) begin
      if (func == F_MUL) begin
        r_state     <= S_BUSY;
        r_out_valid <= 1'b0;
        r_acc       <= '0;
        r_mcand     <= {{WIDTH{1'b0}}, a};
        r_mplier    <= b;
        r_cnt       <= '0;
      end else begin
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_carry     <= w_c;
        r_overflow  <= w_v;
        r_zero      <= (w_res == '0);
      end
    end else begin
      case (r_state)
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // the last partial product goes straight into the output registers
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next[WIDTH-1:0];
            r_carry     <= 1'b0;
            r_overflow  <= (w_acc_next[2*WIDTH-1:WIDTH] != '0);
            r_zero      <= (w_acc_next[WIDTH-1:0] == '0);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed and randomized self-checking bench for seq_alu
// Expected values come from an integer-arithmetic reference model of each opcode.
module tb_seq_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] func;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       carry;
  logic       overflow;
  logic       zero;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] r, output logic c, output logic v, output logic z);
    int ux, uy, sx, sy, t;
    ux = x; uy = y; sx = $signed(x); sy = $signed(y);
    r = 8'h00; c = 1'b0; v = 1'b0;
    case (f)
      3'd0: begin t = ux + uy; r = t[7:0]; c = (t > 255); v = (sx + sy > 127) || (sx + sy < -128); end
      3'd1: begin t = ux - uy; r = t[7:0]; c = (ux >= uy); v = (sx - sy > 127) || (sx - sy < -128); end
      3'd2: r = ~x;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = (sx < sy) ? 8'd1 : 8'd0;
      default: begin t = ux * uy; r = t[7:0]; v = (t > 255); end
    endcase
    z = (r == 8'h00);
  endfunction

  // Issues one command from IDLE, checks latency and outputs, optionally stalls the sink.
  task automatic run_op(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y, input int hold);
    logic [7:0] er;
    logic ec, ev, ez;
    int n;
    model(f, x, y, er, ec, ev, ez);
    @(negedge clk);
    func = f; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1 check("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      n++;
    end
    check("latency", n, (f == 3'd7) ? 9 : 1);
    check("result", result, er);
    check("flags", {carry, overflow, zero}, {ec, ev, ez});
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        check("hold", {out_valid, result, carry, overflow, zero}, {1'b1, er, ec, ev, ez});
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("drained", out_valid, 0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; func = 3'd0; a = 8'h00; b = 8'h00;

    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_state", {out_valid, result, carry, overflow, zero}, 12'h000);
    end
    rst = 1'b0;
    #1 check("in_ready_after_rst", in_ready, 1);

    run_op(3'd0, 8'h7F, 8'h01, 0);
    check("add_ovf_result", result, 8'h80);
    run_op(3'd1, 8'h00, 8'h01, 0);
    check("sub_borrow", {result, carry, overflow}, {8'hFF, 2'b00});
    run_op(3'd6, 8'h80, 8'h01, 0);
    check("slt_neg", result, 8'h01);
    run_op(3'd6, 8'h01, 8'h80, 0);
    check("slt_pos", {result, zero}, {8'h00, 1'b1});
    run_op(3'd7, 8'h10, 8'h10, 0);
    check("mul_trunc", {result, overflow, zero}, {8'h00, 2'b11});
    run_op(3'd7, 8'h0F, 8'h03, 2);
    check("mul_small", {result, overflow}, {8'h2D, 1'b0});

    // Backpressure, then a back-to-back accept in DONE
    @(negedge clk);
    func = 3'd1; a = 8'h00; b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
    #1 check("bp_accept", in_ready, 1);
    @(negedge clk);
    func = 3'd5; a = 8'hF0; b = 8'hFF;
    check("bp_first", {out_valid, result}, {1'b1, 8'hFF});
    repeat (5) begin
      @(negedge clk);
      check("bp_stable", {out_valid, result, carry, overflow, zero}, {1'b1, 8'hFF, 3'b000});
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1 check("b2b_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_result", {out_valid, result, zero}, {1'b1, 8'h0F, 1'b0});
    @(negedge clk);
    check("b2b_drained", out_valid, 0);

    // Reset in the middle of a multiply
    func = 3'd7; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midmul_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midmul_no_valid", seen, 0);
    run_op(3'd0, 8'h01, 8'h01, 0);
    check("post_rst_add", result, 8'h02);

    for (int i = 0; i < 40; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked ALU. It is the registered successor of the team's 4-bit combinational ALU. It accepts one operation per transaction over a valid/ready input port and computes in two's complement at width WIDTH. It returns the result and flags over a valid/ready output port. ADD, SUB, the logic ops and SLT complete in one cycle; MUL is a multi-cycle shift-add. The block sits between an operand/command source (register file or test sequencer) and a result sink that may apply backpressure.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range WIDTH >= 2.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command/operands present.
- in_ready  out  1  block can accept a command this cycle.
- func  in  3  opcode: 0 ADD, 1 SUB, 2 NOT, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 MUL.
- a  in  WIDTH  operand A, two's complement.
- b  in  WIDTH  operand B, two's complement.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  sink accepts result this cycle.
- result  out  WIDTH  operation result.
- carry  out  1  carry/no-borrow flag.
- overflow  out  1  signed overflow (ADD/SUB) or product truncation (MUL).
- zero  out  1  result == 0.

## Operation
- States:
  - IDLE: no result held.
  - BUSY: MUL iterating.
  - DONE: result held, out_valid=1.
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
- An input handshake is in_valid && in_ready. On a handshake, func, a and b are captured into internal registers. Input pins are ignored at all other times, including during BUSY.
- Transitions:
  - IDLE to DONE: handshake with func != 7.
  - IDLE to BUSY: handshake with func == 7.
  - BUSY to DONE: after the WIDTH-th iteration.
  - DONE to IDLE: out_ready && !in_valid.
  - DONE to DONE or BUSY: out_ready && in_valid, a back-to-back accept. The new command is handled exactly as from IDLE.
  - DONE with out_ready=0: stays in DONE. result and all flags stay stable.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: {carry,result} = a + b. overflow = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - SUB: {carry,result} = a + ~b + 1, so carry=1 means no borrow. overflow = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - NOT, AND, OR, XOR: bitwise result (NOT uses a only). carry=0, overflow=0.
  - SLT: result = 1 if signed a < signed b, else 0 (zero-extended). carry=0, overflow=0.
  - MUL: unsigned a*b using a 2*WIDTH-bit accumulator, one partial product per cycle, LSB of b first. result = low WIDTH bits. overflow = 1 if the high WIDTH bits are nonzero. carry=0.
- zero = (result == 0) for every op, registered together with result.
- Outputs change only on entry to DONE or on reset.

## Timing
- Reset: asserting rst for one edge puts the block in IDLE with out_valid=0, result=0, carry=0, overflow=0, zero=0, and clears the MUL counter and accumulator. in_ready=0 while rst is high and 1 in the first cycle after.
- Reset mid-MUL (in BUSY) or in DONE: the operation and held result are discarded, with no output handshake.
- Single-cycle ops: handshake at edge T; out_valid=1 in the cycle following T.
- MUL: handshake at edge T; BUSY for WIDTH cycles; out_valid=1 from edge T+WIDTH+1 (latency WIDTH+1 cycles).
- Throughput: one single-cycle op per clock when out_ready is held high, via back-to-back accept in DONE. MUL allows one op per WIDTH+1 cycles.
- out_valid is never deasserted without an out_ready handshake, except by rst.

## Test plan
- Reset/idle, WIDTH=8: assert rst 2 cycles -> out_valid=0, result=0x00, all flags 0, in_ready=0 during rst, in_ready=1 on the next cycle.
- ADD overflow: ADD a=0x7F, b=0x01 -> result=0x80, overflow=1, carry=0, zero=0, out_valid one cycle after accept.
- SUB borrow and SLT signed:
  - SUB a=0x00, b=0x01 -> result=0xFF, carry=0, overflow=0.
  - SLT a=0x80, b=0x01 -> result=0x01.
  - SLT a=0x01, b=0x80 -> result=0x00, zero=1.
- MUL latency/truncation:
  - MUL a=0x10, b=0x10 -> result=0x00, overflow=1, zero=1, out_valid exactly 9 cycles after accept. Changing a/b during BUSY has no effect.
  - MUL a=0x0F, b=0x03 -> result=0x2D, overflow=0.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles with a result in DONE -> result and flags stable, in_ready=0. Then raise out_ready with in_valid=1 (XOR 0xF0^0xFF) -> accepted the same cycle, next result=0x0F.
- Reset mid-MUL: assert rst 3 cycles into a MUL -> out_valid never rises for that MUL, block is IDLE, and the next ADD 0x01+0x01 returns 0x02.
